bf_program_buffer: RTL and testbench

- Downstream consumer of the keypad driver's edit-mode symbol stream.
- Stores Brainfuck opcodes in an on-chip program RAM and applies append/backspace edits.
- Tracks loop-bracket nesting depth and pops the keypad queue through an explicit pull handshake.
- In execute mode it serves the interpreter a registered read port indexed by the program counter.

---
 rtl/bf_program_buffer.sv | 233 +++++++++++++++++++++++
 tb/tb_bf_program_buffer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_program_buffer.sv
// bf_program_buffer: Brainfuck program store fed by the keypad driver.
// Edit mode (run=0) appends or backspaces opcodes, keeping the loop-bracket
// nesting depth up to date. Each consumed symbol is acknowledged with a
// one-cycle sym_pull pulse. Execute mode (run=1) serves the interpreter a
// registered read port. Reads at or beyond prog_len return 0 (halt).
// Optional feature macro: BF_PROG_ECHO_EN adds the echo_valid/echo_code/echo_del
// stream that mirrors every accepted edit to the display driver.
module bf_program_buffer #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          run,
    input  logic          clear,
    input  logic          sym_valid,
    input  logic          sym_cmd,
    input  logic [3:0]    sym_code,
    output logic          sym_pull,
    input  logic [AW-1:0] rd_addr,
    output logic [3:0]    rd_data,
    output logic [AW:0]   prog_len,
    output logic [AW:0]   depth,
    output logic          balanced,
    output logic          full,
    output logic          busy,
    output logic          err
`ifdef BF_PROG_ECHO_EN
    ,
    output logic          echo_valid,
    output logic [3:0]    echo_code,
    output logic          echo_del
`endif
);

    localparam int          DEPTH    = 2 ** AW;
    localparam logic [AW:0] DEPTH_L  = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LEN_ONE  = (AW + 1)'(1);
    localparam logic [3:0]  CODE_LOL = 4'd7;
    localparam logic [3:0]  CODE_LOR = 4'd8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DEL_RD    = 2'd1,
        DEL_UPD   = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [AW:0] prog_len_reg, prog_len_next;
    logic [AW:0] depth_reg, depth_next;
    logic        pull_reg, pull_next;
    logic        err_reg, err_next;
    logic        clear_pend_reg, clear_pend_next;
    logic        wr_en;

    // Program RAM with a single registered read port shared by the
    // interpreter and the delete path.
    logic [3:0]    mem [DEPTH];
    logic [3:0]    mem_q_reg;
    logic          rd_valid_reg;
    logic [AW-1:0] port_addr;
    logic [AW:0]   last_idx;

    logic code_ok;
    logic append_ok;
    logic full_w;

    assign full_w    = (prog_len_reg == DEPTH_L);
    assign last_idx  = prog_len_reg - LEN_ONE;
    assign code_ok   = (sym_code >= 4'd1) && (sym_code <= 4'd10);
    // A closing bracket with nothing open would make the program unbalanced
    // in a way no later edit could repair, so it is refused up front.
    assign append_ok = code_ok && !full_w &&
                       !((sym_code == CODE_LOR) && (depth_reg == '0));
    // The delete path borrows the read port for one cycle to learn which
    // opcode it is about to drop.
    assign port_addr = (state_reg == DEL_RD) ? last_idx[AW-1:0] : rd_addr;

    // Next-state and next-value logic for the edit FSM.
    always_comb begin
        state_next      = state_reg;
        prog_len_next   = prog_len_reg;
        depth_next      = depth_reg;
        pull_next       = 1'b0;
        err_next        = 1'b0;
        clear_pend_next = clear_pend_reg;
        wr_en           = 1'b0;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    // Clear wins over a same-cycle edit; the symbol stays
                    // queued in the driver.
                    prog_len_next = '0;
                    depth_next    = '0;
                end else if (!run && sym_valid) begin
                    if (!sym_cmd) begin
                        pull_next  = 1'b1;
                        state_next = WAIT_DROP;
                        if (append_ok) begin
                            wr_en         = 1'b1;
                            prog_len_next = prog_len_reg + LEN_ONE;
                            if (sym_code == CODE_LOL) begin
                                depth_next = depth_reg + LEN_ONE;
                            end else if (sym_code == CODE_LOR) begin
                                depth_next = depth_reg - LEN_ONE;
                            end
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (prog_len_reg == '0) begin
                        // Backspace on an empty program is a harmless no-op.
                        pull_next  = 1'b1;
                        state_next = WAIT_DROP;
                    end else begin
                        state_next = DEL_RD;
                    end
                end
            end
            DEL_RD: begin
                if (clear) begin
                    clear_pend_next = 1'b1;
                end
                state_next = DEL_UPD;
            end
            DEL_UPD: begin
                if (clear) begin
                    clear_pend_next = 1'b1;
                end
                prog_len_next = last_idx;
                if (mem_q_reg == CODE_LOL) begin
                    depth_next = depth_reg - LEN_ONE;
                end else if (mem_q_reg == CODE_LOR) begin
                    depth_next = depth_reg + LEN_ONE;
                end
                pull_next  = 1'b1;
                state_next = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (clear || clear_pend_reg) begin
                    prog_len_next   = '0;
                    depth_next      = '0;
                    clear_pend_next = 1'b0;
                end
                // Hold here until the driver drops "available" so the same
                // key is never consumed twice.
                if (!sym_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= IDLE;
            prog_len_reg   <= '0;
            depth_reg      <= '0;
            pull_reg       <= 1'b0;
            err_reg        <= 1'b0;
            clear_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            prog_len_reg   <= prog_len_next;
            depth_reg      <= depth_next;
            pull_reg       <= pull_next;
            err_reg        <= err_next;
            clear_pend_reg <= clear_pend_next;
        end
    end

    // RAM write port: appends land at the current end of program.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[prog_len_reg[AW-1:0]] <= sym_code;
        end
    end

    // RAM read port, kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        mem_q_reg <= mem[port_addr];
    end

    // Registered in-range flag that masks stale RAM contents to halt (0).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= ({1'b0, port_addr} < prog_len_reg);
        end
    end

    assign rd_data  = rd_valid_reg ? mem_q_reg : 4'd0;
    assign sym_pull = pull_reg;
    assign err      = err_reg;
    assign prog_len = prog_len_reg;
    assign depth    = depth_reg;
    assign balanced = (depth_reg == '0);
    assign full     = full_w;
    assign busy     = (state_reg != IDLE);

`ifdef BF_PROG_ECHO_EN
    logic       echo_valid_reg;
    logic [3:0] echo_code_reg;
    logic       echo_del_reg;

    // Mirror each successful append and each completed non-empty delete.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            echo_valid_reg <= 1'b0;
            echo_code_reg  <= 4'd0;
            echo_del_reg   <= 1'b0;
        end else begin
            echo_valid_reg <= wr_en || (state_reg == DEL_UPD);
            if (wr_en) begin
                echo_code_reg <= sym_code;
                echo_del_reg  <= 1'b0;
            end else if (state_reg == DEL_UPD) begin
                echo_code_reg <= mem_q_reg;
                echo_del_reg  <= 1'b1;
            end
        end
    end

    assign echo_valid = echo_valid_reg;
    assign echo_code  = echo_code_reg;
    assign echo_del   = echo_del_reg;
`endif

endmodule

// File: tb/tb_bf_program_buffer.sv
// Testbench for bf_program_buffer (AW=2, four-symbol program store).
// The reference model keeps the program as a queue of opcodes. Bracket depth
// is recounted from the whole queue.
module tb_bf_program_buffer;

    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;

    logic          clk;
    logic          resetn;
    logic          run;
    logic          clear;
    logic          sym_valid;
    logic          sym_cmd;
    logic [3:0]    sym_code;
    logic          sym_pull;
    logic [AW-1:0] rd_addr;
    logic [3:0]    rd_data;
    logic [AW:0]   prog_len;
    logic [AW:0]   depth;
    logic          balanced;
    logic          full;
    logic          busy;
    logic          err;
`ifdef BF_PROG_ECHO_EN
    logic          echo_valid;
    logic [3:0]    echo_code;
    logic          echo_del;
`endif

    int checks;
    int failures;
    logic [3:0] prog [$];

    bf_program_buffer #(.AW(AW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .run       (run),
        .clear     (clear),
        .sym_valid (sym_valid),
        .sym_cmd   (sym_cmd),
        .sym_code  (sym_code),
        .sym_pull  (sym_pull),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .prog_len  (prog_len),
        .depth     (depth),
        .balanced  (balanced),
        .full      (full),
        .busy      (busy),
        .err       (err)
`ifdef BF_PROG_ECHO_EN
        ,
        .echo_valid(echo_valid),
        .echo_code (echo_code),
        .echo_del  (echo_del)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_depth();
        int d = 0;
        foreach (prog[i]) begin
            if (prog[i] == 4'd7) d++;
            else if (prog[i] == 4'd8) d--;
        end
        return d;
    endfunction

    // Compare the status outputs against the model after an operation.
    task automatic check_status(input string tag);
        logic [AW:0] exp_len;
        logic [AW:0] exp_depth;
        exp_len   = (AW + 1)'(prog.size());
        exp_depth = (AW + 1)'(model_depth());
        checks++;
        if (prog_len !== exp_len) begin
            failures++;
            $display("FAIL %s prog_len got=%0d exp=%0d", tag, prog_len, exp_len);
        end
        checks++;
        if (depth !== exp_depth) begin
            failures++;
            $display("FAIL %s depth got=%0d exp=%0d", tag, depth, exp_depth);
        end
        checks++;
        if (balanced !== (exp_depth == '0)) begin
            failures++;
            $display("FAIL %s balanced got=%0b exp=%0b", tag, balanced, exp_depth == '0);
        end
        checks++;
        if (full !== (prog.size() == DEPTH)) begin
            failures++;
            $display("FAIL %s full got=%0b exp=%0b", tag, full, prog.size() == DEPTH);
        end
    endtask

    // One keypad transaction: hold "available" until pulled, then drop it.
    task automatic do_edit(input bit cmd, input logic [3:0] code, input string tag);
        bit ok;
        int exp_lat;
        bit exp_err;
        int lat;
        int err_cnt;
        bit got;
        if (!cmd) begin
            ok = (code >= 4'd1) && (code <= 4'd10) && (prog.size() < DEPTH) &&
                 !((code == 4'd8) && (model_depth() == 0));
            exp_lat = 1;
            exp_err = !ok;
            if (ok) prog.push_back(code);
        end else begin
            exp_err = 1'b0;
            if (prog.size() == 0) begin
                exp_lat = 1;
            end else begin
                exp_lat = 3;
                void'(prog.pop_back());
            end
        end
        @(negedge clk);
        sym_valid = 1'b1;
        sym_cmd   = cmd;
        sym_code  = code;
        lat = 0;
        err_cnt = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (err) err_cnt++;
            if (sym_pull) got = 1'b1;
        end
        sym_valid = 1'b0;
        checks++;
        if (!got || lat != exp_lat) begin
            failures++;
            $display("FAIL %s pull_latency got=%0d exp=%0d pulled=%0b", tag, lat, exp_lat, got);
        end
        checks++;
        if (err_cnt != int'(exp_err)) begin
            failures++;
            $display("FAIL %s err_pulses got=%0d exp=%0d", tag, err_cnt, exp_err);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sym_pull !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL %s post_idle busy=%0b pull=%0b err=%0b exp all 0", tag, busy, sym_pull, err);
        end
        check_status(tag);
        $display("TXN %s cmd=%0d code=%0d lat=%0d err=%0d len=%0d depth=%0d",
                 tag, cmd, code, lat, err_cnt, prog_len, depth);
    endtask

    task automatic do_clear(input string tag);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        prog.delete();
        check_status(tag);
        $display("TXN %s clear len=%0d depth=%0d", tag, prog_len, depth);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if (prog_len !== '0 || depth !== '0 || rd_data !== 4'd0 || sym_pull !== 1'b0 ||
            err !== 1'b0 || busy !== 1'b0 || balanced !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset len=%0d depth=%0d rd=%0d pull=%0b err=%0b busy=%0b bal=%0b full=%0b exp 0/0/0/0/0/0/1/0",
                     prog_len, depth, rd_data, sym_pull, err, busy, balanced, full);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        prog.delete();
        $display("TXN reset len=%0d depth=%0d", prog_len, depth);
    endtask

    task automatic test_read(input string tag);
        logic [3:0] exp;
        @(negedge clk);
        run = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = a[AW-1:0];
            @(negedge clk);
            exp = (a < prog.size()) ? prog[a] : 4'd0;
            checks++;
            if (rd_data !== exp) begin
                failures++;
                $display("FAIL %s rd_data[%0d] got=%0d exp=%0d", tag, a, rd_data, exp);
            end
            $display("TXN %s read addr=%0d data=%0d", tag, a, rd_data);
        end
        run = 1'b0;
    endtask

    task automatic test_append_and_full();
        do_edit(1'b0, 4'd1, "app1");
        do_edit(1'b0, 4'd7, "app7");
        do_edit(1'b0, 4'd2, "app2");
        do_edit(1'b0, 4'd8, "app8");
        test_read("read_full");
        do_edit(1'b0, 4'd1, "app_over_full");
        do_edit(1'b0, 4'd11, "app_bad_code");
    endtask

    task automatic test_unmatched_close();
        do_clear("clr_unmatched");
        do_edit(1'b0, 4'd8, "app8_empty");
        do_edit(1'b0, 4'd0, "app_code0");
    endtask

    task automatic test_delete();
        do_clear("clr_delete");
        do_edit(1'b0, 4'd7, "d_app7a");
        do_edit(1'b0, 4'd7, "d_app7b");
        do_edit(1'b0, 4'd3, "d_app3");
        do_edit(1'b1, 4'd0, "del1");
        do_edit(1'b1, 4'd0, "del2");
        do_edit(1'b1, 4'd0, "del3");
        do_edit(1'b1, 4'd0, "del_empty");
        test_read("read_empty");
    endtask

    task automatic test_hold();
        int pulls;
        do_clear("clr_hold");
        @(negedge clk);
        sym_valid = 1'b1;
        sym_cmd   = 1'b0;
        sym_code  = 4'd5;
        pulls = 0;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            if (sym_pull) pulls++;
        end
        sym_valid = 1'b0;
        prog.push_back(4'd5);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pulls != 1) begin
            failures++;
            $display("FAIL hold pulls got=%0d exp=1", pulls);
        end
        check_status("hold");
        $display("TXN hold pulls=%0d len=%0d", pulls, prog_len);
    endtask

    task automatic test_run_ignore();
        int pulls;
        @(negedge clk);
        run       = 1'b1;
        sym_valid = 1'b1;
        sym_cmd   = 1'b0;
        sym_code  = 4'd6;
        pulls = 0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (sym_pull || busy) pulls++;
        end
        sym_valid = 1'b0;
        run       = 1'b0;
        checks++;
        if (pulls != 0) begin
            failures++;
            $display("FAIL run_ignore pull_or_busy_cycles got=%0d exp=0", pulls);
        end
        check_status("run_ignore");
        $display("TXN run_ignore cycles=%0d len=%0d", pulls, prog_len);
    endtask

    task automatic test_clear_append();
        @(negedge clk);
        clear     = 1'b1;
        sym_valid = 1'b1;
        sym_cmd   = 1'b0;
        sym_code  = 4'd1;
        @(posedge clk);
        @(negedge clk);
        prog.delete();
        checks++;
        if (sym_pull !== 1'b0) begin
            failures++;
            $display("FAIL clear_append pull got=%0b exp=0", sym_pull);
        end
        clear     = 1'b0;
        sym_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (sym_pull !== 1'b0) begin
            failures++;
            $display("FAIL clear_append late_pull got=%0b exp=0", sym_pull);
        end
        check_status("clear_append");
        $display("TXN clear_append len=%0d pull=%0b", prog_len, sym_pull);
    endtask

    task automatic test_reset_mid_del();
        do_edit(1'b0, 4'd7, "rst_app7");
        do_edit(1'b0, 4'd4, "rst_app4");
        @(negedge clk);
        sym_valid = 1'b1;
        sym_cmd   = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_del busy got=%0b exp=1", busy);
        end
        resetn = 1'b0;
        #1;
        prog.delete();
        checks++;
        if (prog_len !== '0 || depth !== '0 || rd_data !== 4'd0 || sym_pull !== 1'b0 ||
            err !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mid_del_reset len=%0d depth=%0d rd=%0d pull=%0b err=%0b busy=%0b exp all 0",
                     prog_len, depth, rd_data, sym_pull, err, busy);
        end
        @(negedge clk);
        sym_valid = 1'b0;
        sym_cmd   = 1'b0;
        resetn    = 1'b1;
        @(negedge clk);
        check_status("after_mid_del_reset");
        $display("TXN mid_del_reset len=%0d busy=%0b", prog_len, busy);
    endtask

    task automatic test_random();
        logic [3:0] code;
        bit cmd;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) code = 4'($urandom_range(0, 15));
            else code = 4'($urandom_range(1, 10));
            cmd = ($urandom_range(0, 2) == 0);
            do_edit(cmd, code, $sformatf("rnd%0d", n));
            if (n % 15 == 14) test_read($sformatf("rnd_read%0d", n));
            if (n == 40) do_clear("rnd_clear");
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        resetn    = 1'b0;
        run       = 1'b0;
        clear     = 1'b0;
        sym_valid = 1'b0;
        sym_cmd   = 1'b0;
        sym_code  = 4'd0;
        rd_addr   = '0;
        test_reset();
        test_append_and_full();
        test_unmatched_close();
        test_delete();
        test_hold();
        test_run_ignore();
        test_clear_append();
        test_random();
        test_reset_mid_del();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
